// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter: FSM state
// encoding, parameter defaults and a counter-width helper.
package fifo_arb_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2,
    ST_FLUSH  = 2'd3
  } arb_state_e;

  // Counter wide enough to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO write port from two
// requesters, with a timed FIFO flush and a sticky overflow flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              flush,
  input  logic              fifo_full,
  input  logic              fifo_overflow,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              fifo_srst,
  output logic              active_id,
  output logic              busy,
  output logic              ovf_err
);

  localparam int BC_W = cnt_width(BURST_LEN);
  localparam int FC_W = cnt_width(FLUSH_CYCLES);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [BC_W-1:0] r_burst_cnt;
  logic [BC_W-1:0] w_burst_cnt_nxt;
  logic [FC_W-1:0] r_flush_cnt;
  logic [FC_W-1:0] w_flush_cnt_nxt;
  logic            r_last_served;
  logic            w_last_served_nxt;
  logic            r_ovf_err;

  logic w_cur_req;
  logic w_oth_req;
  logic w_xfer;
  logic w_burst_end;

  // Grants are combinational so a word is written in the cycle it is offered.
  assign gnt0       = (r_state == ST_SERVE0) && req0 && !fifo_full;
  assign gnt1       = (r_state == ST_SERVE1) && req1 && !fifo_full;
  assign fifo_wr_en = gnt0 | gnt1;
  assign fifo_din   = gnt0 ? din0 : (gnt1 ? din1 : '0);
  assign fifo_srst  = (r_state == ST_FLUSH);
  assign busy       = (r_state != ST_IDLE);
  assign active_id  = (r_state == ST_SERVE1);
  assign ovf_err    = r_ovf_err;

  assign w_cur_req   = (r_state == ST_SERVE1) ? req1 : req0;
  assign w_oth_req   = (r_state == ST_SERVE1) ? req0 : req1;
  assign w_xfer      = gnt0 | gnt1;
  assign w_burst_end = !w_cur_req || (w_xfer && (r_burst_cnt == BC_LAST));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt       = r_state;
    w_burst_cnt_nxt   = r_burst_cnt;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_last_served_nxt = r_last_served;

    if (r_state == ST_FLUSH) begin
      if (r_flush_cnt == FC_LAST) begin
        // A flush still asserted at the end simply starts another full pulse.
        w_flush_cnt_nxt = '0;
        if (!flush) w_state_nxt = ST_IDLE;
      end else begin
        w_flush_cnt_nxt = r_flush_cnt + FC_W'(1);
      end
    end else if (flush) begin
      w_state_nxt     = ST_FLUSH;
      w_flush_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req0 && (!req1 || r_last_served)) begin
            w_state_nxt       = ST_SERVE0;
            w_burst_cnt_nxt   = '0;
            w_last_served_nxt = 1'b0;
          end else if (req1) begin
            w_state_nxt       = ST_SERVE1;
            w_burst_cnt_nxt   = '0;
            w_last_served_nxt = 1'b1;
          end
        end
        ST_SERVE0, ST_SERVE1: begin
          if (w_burst_end) begin
            w_burst_cnt_nxt = '0;
            if (w_oth_req) begin
              w_state_nxt       = (r_state == ST_SERVE0) ? ST_SERVE1 : ST_SERVE0;
              w_last_served_nxt = (r_state == ST_SERVE0);
            end else if (!w_cur_req) begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_xfer) begin
            w_burst_cnt_nxt = r_burst_cnt + BC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_burst_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_last_served <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      r_state       <= w_state_nxt;
      r_burst_cnt   <= w_burst_cnt_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_last_served <= w_last_served_nxt;
    end
  end

  // An overflow arriving during a flush still wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
    end else if (fifo_overflow) begin
      r_ovf_err <= 1'b1;
    end else if (r_state == ST_FLUSH) begin
      r_ovf_err <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of every data bus.
REQ-002 Parameter BURST_LEN, default 4, maximum words accepted from one requester per grant.
REQ-003 Parameter FLUSH_CYCLES, default 2, length of the fifo_srst pulse.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock, shared with the FIFO.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req0 / req1  in  1  requester 0 / 1 has a valid word.
REQ-008 din0 / din1  in  DATA_W  requester 0 / 1 data.
REQ-009 gnt0 / gnt1  out  1  word on dinX is accepted this cycle.
REQ-010 flush  in  1  request to clear the FIFO.
REQ-011 fifo_full  in  1  FIFO full flag.
REQ-012 fifo_overflow  in  1  FIFO overflow pulse.
REQ-013 fifo_din  out  DATA_W  FIFO write data.
REQ-014 fifo_wr_en  out  1  FIFO write enable.
REQ-015 fifo_srst  out  1  FIFO synchronous reset.
REQ-016 active_id  out  1  requester owning the port (valid when busy=1).
REQ-017 busy  out  1  high in SERVE0, SERVE1 or FLUSH.
REQ-018 ovf_err  out  1  sticky error: fifo_overflow seen since reset or flush.

Function
REQ-019 FSM states SHALL be IDLE, SERVE0, SERVE1, FLUSH.
REQ-020 gntX SHALL be combinational: state==SERVEX and reqX and !fifo_full; at most one grant high.
REQ-021 fifo_wr_en SHALL equal gnt0|gnt1; fifo_din SHALL be din of the granted requester, zero otherwise; zero write latency.
REQ-022 IDLE: no grant; next SERVE0 if req0 and (!req1 or last_served==1); else SERVE1 if req1; else stay.
REQ-023 Entering SERVEX SHALL set last_served=X and burst_cnt=0.
REQ-024 Each transfer in SERVEX SHALL increment burst_cnt; fifo_full stalls hold state and count.
REQ-025 SERVEX SHALL end when reqX is low, or a transfer occurs with burst_cnt==BURST_LEN-1.
REQ-026 On end: go to the other SERVE if the other req is high; else stay in SERVEX with burst_cnt=0 if reqX is high; else IDLE.
REQ-027 flush high in any state SHALL force FLUSH next cycle, aborting a burst; grants low while in FLUSH.
REQ-028 FLUSH SHALL drive fifo_srst high for exactly FLUSH_CYCLES cycles, clear ovf_err, then go to IDLE.
REQ-029 flush still high on FLUSH exit SHALL restart FLUSH, not go to IDLE.
REQ-030 ovf_err SHALL set on any cycle with fifo_overflow=1 and hold until flush or reset.
REQ-031 burst_cnt width SHALL be clog2(BURST_LEN), minimum 1; it never wraps past BURST_LEN-1.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, burst_cnt 0, last_served 1, ovf_err 0, flush counter 0.
REQ-033 During reset all outputs SHALL be 0: gnt0, gnt1, fifo_wr_en, fifo_din, fifo_srst, busy, active_id.
REQ-034 Reset mid-burst or mid-flush SHALL drop any flush in progress; first grant is possible 2 cycles after deassertion.

Structure
REQ-035 Package fifo_arb_pkg SHALL hold the state enum plus DATA_W, BURST_LEN and FLUSH_CYCLES defaults.
REQ-036 The block SHALL be a single module with no sub-modules; the FIFO is instantiated beside it, not inside it.

Verification
REQ-037 Bench SHALL instance the 16-deep 8-bit FIFO with the arbiter; clk period 20 ns.
REQ-038 req0 only, din0=0,8,16..., 6 words -> IDLE 1 cycle, then 6 consecutive writes (burst restart at 4), data_count=6.
REQ-039 req0 and req1 held from reset -> SERVE0 writes 4, SERVE1 writes 4, alternating; no idle cycle at switches.
REQ-040 FIFO prefilled to 16 then req1 -> gnt1 low while fifo_full; one read frees a slot -> exactly one gnt1 next cycle.
REQ-041 flush at 2nd word of a SERVE0 burst -> grants drop next cycle, fifo_srst high 2 cycles, data_count=0, then IDLE.
REQ-042 Force fifo_overflow for 1 cycle -> ovf_err=1 held; a later flush -> ovf_err=0.
REQ-043 rst_n low mid-SERVE1 -> all outputs 0 immediately; after release, req0+req1 -> SERVE0 served first.
